// File: rtl/gpio_bank.sv
// gpio_bank: WIDTH-pin Wishbone GPIO bank with per-pin direction, atomic
// output set/clear, synchronised inputs and optional per-pin edge interrupts.
// Zero-wait-state slave: ack and read data are combinational from the strobe.
// Build option: define GPIO_IRQ_EN to include the edge-interrupt logic
// (RISE_EN, FALL_EN, IRQ_STAT, previous-sample flops and o_irq).
module gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic [31:0]      i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio_in,
  output logic [WIDTH-1:0] o_gpio_out,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  // Register word index, decoded from byte address bits [4:2].
  typedef enum logic [2:0] {
    ADDR_OUT      = 3'd0,
    ADDR_IN       = 3'd1,
    ADDR_DIR      = 3'd2,
    ADDR_OUT_SET  = 3'd3,
    ADDR_OUT_CLR  = 3'd4,
    ADDR_RISE_EN  = 3'd5,
    ADDR_FALL_EN  = 3'd6,
    ADDR_IRQ_STAT = 3'd7
  } reg_addr_e;

  reg_addr_e                         adr;
  logic                              wr;
  logic [WIDTH-1:0]                  wdat;
  logic [WIDTH-1:0]                  out_q;
  logic [WIDTH-1:0]                  dir_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  in_sync;
  logic [WIDTH-1:0]                  rd_field;

  assign adr     = reg_addr_e'(i_wb_adr[4:2]);
  assign wr      = i_wb_stb & i_wb_we;
  assign wdat    = i_wb_dat[WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];

  // Address and data bits outside the decoded/implemented range are ignored.
  logic unused_adr;
  logic unused_dat;
  assign unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};
  generate
    if (WIDTH < 32) begin : g_dat_pad
      assign unused_dat = ^i_wb_dat[31:WIDTH];
    end else begin : g_dat_full
      assign unused_dat = 1'b0;
    end
  endgenerate

  // Ack follows the strobe combinationally so it can never outlast it.
  assign o_wb_ack   = i_wb_stb;
  assign o_gpio_out = out_q;
  assign o_gpio_oe  = dir_q;

  // Output latch and direction: plain writes plus atomic set/clear.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (wr) begin
      case (adr)
        ADDR_OUT:     out_q <= wdat;
        ADDR_OUT_SET: out_q <= out_q | wdat;
        ADDR_OUT_CLR: out_q <= out_q & ~wdat;
        ADDR_DIR:     dir_q <= wdat;
        default:      ;
      endcase
    end
  end

  // Input synchroniser: pad enters stage 0, IN is the last stage.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_gpio_in};
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] irq_stat_q;
  logic [WIDTH-1:0] irq_set;
  logic [WIDTH-1:0] irq_clr;

  // Edge detect against the previous synchronised sample, gated by enables.
  assign irq_set = (in_sync & ~prev_q & rise_en_q) |
                   (~in_sync & prev_q & fall_en_q);
  assign irq_clr = (wr && adr == ADDR_IRQ_STAT) ? wdat : '0;
  assign o_irq   = |irq_stat_q;

  // Edge enables, previous-sample flops and sticky status (set beats W1C).
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      prev_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
    end else begin
      prev_q     <= in_sync;
      irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
      if (wr && adr == ADDR_RISE_EN) rise_en_q <= wdat;
      if (wr && adr == ADDR_FALL_EN) fall_en_q <= wdat;
    end
  end
`else
  assign o_irq = 1'b0;
`endif

  // Read mux: addressed register, zero-extended; zero whenever stb is low.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_field = '0;
    case (adr)
      ADDR_OUT:      rd_field = out_q;
      ADDR_IN:       rd_field = in_sync;
      ADDR_DIR:      rd_field = dir_q;
`ifdef GPIO_IRQ_EN
      ADDR_RISE_EN:  rd_field = rise_en_q;
      ADDR_FALL_EN:  rd_field = fall_en_q;
      ADDR_IRQ_STAT: rd_field = irq_stat_q;
`endif
      default:       rd_field = '0;
    endcase
    o_wb_rdt = '0;
    if (i_wb_stb) o_wb_rdt[WIDTH-1:0] = rd_field;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed self-checking bench for gpio_bank (WIDTH=8,
// SYNC_STAGES=2). Interrupt scenarios follow the GPIO_IRQ_EN build option.
module tb_gpio_bank;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic [31:0]      adr;
  logic [31:0]      dat;
  logic             we;
  logic             stb;
  logic [31:0]      rdt;
  logic             ack;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  gpio_bank #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_wb_adr   (adr),
    .i_wb_dat   (dat),
    .i_wb_we    (we),
    .i_wb_stb   (stb),
    .o_wb_rdt   (rdt),
    .o_wb_ack   (ack),
    .i_gpio_in  (gpio_in),
    .o_gpio_out (gpio_out),
    .o_gpio_oe  (gpio_oe),
    .o_irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle write: set up after negedge, committed at the posedge.
  task automatic wb_write(input logic [2:0] idx, input logic [31:0] data);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = {27'd0, idx, 2'b00}; dat = data;
    #1;
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL wr_ack idx=%0d got=%b exp=1", idx, ack);
    else pass_cnt++;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0; dat = '0;
  endtask

  // Combinational read, sampled away from any clock edge.
  task automatic wb_read(input logic [2:0] idx, output logic [31:0] data);
    stb = 1'b1; we = 1'b0; adr = {27'd0, idx, 2'b00};
    #1;
    data = rdt;
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL rd_ack idx=%0d got=%b exp=1", idx, ack);
    else pass_cnt++;
    stb = 1'b0;
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0; gpio_in = 8'hFF;
    stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
    step(3);
    total_cnt++;
    if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0 || rdt !== 32'h0)
      $display("FAIL reset_outs out=%h oe=%h irq=%b rdt=%h exp=0", gpio_out, gpio_oe, irq, rdt);
    else pass_cnt++;
    wb_read(3'd1, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL reset_in got=%h exp=0", r);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    wb_read(3'd1, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL in_early got=%h exp=0", r);
    else pass_cnt++;
    step(2);
    wb_read(3'd1, r);
    total_cnt++;
    if (r !== 32'hFF) $display("FAIL in_settled got=%h exp=ff", r);
    else pass_cnt++;
    step(2);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq);
    else pass_cnt++;
  endtask

  task automatic test_outputs();
    logic [31:0] r;
    wb_write(3'd0, 32'h0000_00A5);
    wb_write(3'd2, 32'h0000_000F);
    wb_write(3'd3, 32'h0000_0010);
    wb_write(3'd4, 32'h0000_0001);
    total_cnt++;
    if (gpio_out !== 8'hB4) $display("FAIL gpio_out got=%h exp=b4", gpio_out);
    else pass_cnt++;
    total_cnt++;
    if (gpio_oe !== 8'h0F) $display("FAIL gpio_oe got=%h exp=0f", gpio_oe);
    else pass_cnt++;
    wb_read(3'd0, r);
    total_cnt++;
    if (r !== 32'hB4) $display("FAIL rd_out got=%h exp=b4", r);
    else pass_cnt++;
    wb_read(3'd2, r);
    total_cnt++;
    if (r !== 32'h0F) $display("FAIL rd_dir got=%h exp=0f", r);
    else pass_cnt++;
    wb_read(3'd3, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL rd_set got=%h exp=0", r);
    else pass_cnt++;
    wb_read(3'd4, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL rd_clr got=%h exp=0", r);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    // Consecutive-cycle set/clear ops each build on the previous result.
    wb_write(3'd0, 32'h0000_0000);
    wb_write(3'd3, 32'h0000_0081);
    wb_write(3'd3, 32'h0000_0042);
    wb_write(3'd4, 32'h0000_0003);
    total_cnt++;
    if (gpio_out !== 8'hC0) $display("FAIL b2b_out got=%h exp=c0", gpio_out);
    else pass_cnt++;
    wb_read(3'd0, r);
    total_cnt++;
    if (r !== 32'hC0) $display("FAIL b2b_rd got=%h exp=c0", r);
    else pass_cnt++;
  endtask

  task automatic test_bounds();
    logic [31:0] r;
    wb_write(3'd0, 32'hFFFF_FFFF);
    wb_read(3'd0, r);
    total_cnt++;
    if (r !== 32'h0000_00FF) $display("FAIL wide_out got=%h exp=000000ff", r);
    else pass_cnt++;
    wb_write(3'd2, 32'hFFFF_FF3C);
    wb_read(3'd2, r);
    total_cnt++;
    if (r !== 32'h0000_003C) $display("FAIL wide_dir got=%h exp=0000003c", r);
    else pass_cnt++;
    // With the strobe low, every address reads zero and ack stays low.
    for (int a = 0; a < 8; a++) begin
      stb = 1'b0; we = 1'b0; adr = 32'(a) << 2;
      #1;
      total_cnt++;
      if (rdt !== 32'h0 || ack !== 1'b0)
        $display("FAIL stb_low idx=%0d rdt=%h ack=%b exp=0", a, rdt, ack);
      else pass_cnt++;
    end
  endtask

`ifdef GPIO_IRQ_EN
  task automatic test_irq();
    logic [31:0] r;
    @(negedge clk);
    gpio_in = 8'h02;
    step(4);
    wb_write(3'd5, 32'h01);
    wb_write(3'd6, 32'h02);
    wb_read(3'd7, r);
    total_cnt++;
    if (r !== 32'h0 || irq !== 1'b0) $display("FAIL irq_idle stat=%h irq=%b exp=0", r, irq);
    else pass_cnt++;
    // Pin0 rises and pin1 falls together.
    @(negedge clk);
    gpio_in = 8'h01;
    step(1);
    step(1);
    wb_read(3'd1, r);
    total_cnt++;
    if (r !== 32'h01 || irq !== 1'b0) $display("FAIL irq_pre in=%h irq=%b exp in=01 irq=0", r, irq);
    else pass_cnt++;
    step(1);
    wb_read(3'd7, r);
    total_cnt++;
    if (r !== 32'h03 || irq !== 1'b1) $display("FAIL irq_edge stat=%h irq=%b exp stat=03 irq=1", r, irq);
    else pass_cnt++;
    // Pin2 toggles with no enable.
    @(negedge clk); gpio_in = 8'h05;
    step(4);
    @(negedge clk); gpio_in = 8'h01;
    step(4);
    wb_read(3'd7, r);
    total_cnt++;
    if (r !== 32'h03) $display("FAIL irq_noen stat=%h exp=03", r);
    else pass_cnt++;
    // W1C one bit.
    wb_write(3'd7, 32'h01);
    wb_read(3'd7, r);
    total_cnt++;
    if (r !== 32'h02 || irq !== 1'b1) $display("FAIL w1c stat=%h irq=%b exp stat=02 irq=1", r, irq);
    else pass_cnt++;
    // Pin1 back high (rise not enabled), then fall lands on the W1C edge.
    @(negedge clk); gpio_in = 8'h03;
    step(4);
    @(negedge clk); gpio_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 32'h1C; dat = 32'h02;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0; dat = '0;
    wb_read(3'd7, r);
    total_cnt++;
    if (r !== 32'h02) $display("FAIL set_beats_clr stat=%h exp=02", r);
    else pass_cnt++;
    // Disabling enables keeps status; a plain W1C then clears it.
    wb_write(3'd6, 32'h00);
    wb_read(3'd7, r);
    total_cnt++;
    if (r !== 32'h02) $display("FAIL en_clr_keep stat=%h exp=02", r);
    else pass_cnt++;
    wb_write(3'd7, 32'h02);
    wb_read(3'd7, r);
    total_cnt++;
    if (r !== 32'h0 || irq !== 1'b0) $display("FAIL w1c_all stat=%h irq=%b exp=0", r, irq);
    else pass_cnt++;
  endtask
`else
  task automatic test_irq_disabled();
    logic [31:0] r;
    wb_write(3'd5, 32'hFF);
    wb_write(3'd6, 32'hFF);
    @(negedge clk); gpio_in = 8'h00;
    step(4);
    @(negedge clk); gpio_in = 8'hFF;
    step(4);
    for (int a = 5; a < 8; a++) begin
      wb_read(3'(a), r);
      total_cnt++;
      if (r !== 32'h0) $display("FAIL noirq_rd idx=%0d got=%h exp=0", a, r);
      else pass_cnt++;
    end
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL noirq_irq got=%b exp=0", irq);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_outputs();
    test_back_to_back();
    test_bounds();
`ifdef GPIO_IRQ_EN
    test_irq();
`else
    test_irq_disabled();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
